// File: rtl/fetch_ctrl_if.sv
// Bus bundle for fetch_ctrl: control inputs, program-load handshake, memory port and status.
// The master modport drives the controller; the slave modport is the controller itself.
interface fetch_ctrl_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            start;
  logic            start_load;
  logic            halt_req;
  logic            load_valid;
  logic            load_ready;
  logic [ILEN-1:0] load_data;
  logic            load_last;
  logic            stall;
  logic            redirect;
  logic [ILEN-1:0] redirect_pc;
  logic [ILEN-1:0] pc;
  logic [ILEN-1:0] wdata;
  logic            write_en;
  logic            fetch_valid;
  logic [1:0]      state;
  logic            misalign_err;
  logic [XLEN-1:0] run_cycles;
  logic [XLEN-1:0] fetch_count;

  modport master (
    output start, start_load, halt_req,
    output load_valid, load_data, load_last,
    output stall, redirect, redirect_pc,
    input  load_ready, pc, wdata, write_en, fetch_valid,
    input  state, misalign_err, run_cycles, fetch_count
  );

  modport slave (
    input  start, start_load, halt_req,
    input  load_valid, load_data, load_last,
    input  stall, redirect, redirect_pc,
    output load_ready, pc, wdata, write_en, fetch_valid,
    output state, misalign_err, run_cycles, fetch_count
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: program load into instruction memory, then sequential fetch
// with stall/redirect/halt. Define FETCH_CTRL_PERF_EN to build the run/fetch perf counters.
module fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter logic [ILEN-1:0] RESET_PC = '0
) (
  input logic        clock,
  input logic        reset_n,
  fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } state_e;

  // The start address is always word aligned, whatever the parameter says.
  localparam logic [ILEN-1:0] ResetPc = {RESET_PC[ILEN-1:2], 2'b00};

  state_e          state_q;
  logic [ILEN-1:0] pc_q;
  logic            misalign_q;

  logic            handshake;
  logic            startAccept;
  logic [ILEN-1:0] pcPlus4;

  assign handshake   = (state_q == LOAD) & bus.load_valid;
  assign startAccept = ((state_q == IDLE) | (state_q == HALT)) & bus.start;
  assign pcPlus4     = pc_q + ILEN'(4);

  assign bus.load_ready   = (state_q == LOAD);
  assign bus.write_en     = handshake;
  assign bus.wdata        = handshake ? bus.load_data : '0;
  assign bus.fetch_valid  = (state_q == RUN) & ~bus.stall;
  assign bus.pc           = pc_q;
  assign bus.state        = state_q;
  assign bus.misalign_err = misalign_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= ResetPc;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (bus.start_load) begin
            state_q    <= LOAD;
            pc_q       <= ResetPc;
            misalign_q <= 1'b0;
          end else if (bus.start) begin
            state_q    <= RUN;
            pc_q       <= ResetPc;
            misalign_q <= 1'b0;
          end
        end
        LOAD: begin
          if (handshake) begin
            if (bus.load_last) begin
              state_q <= IDLE;
              pc_q    <= ResetPc;
            end else begin
              pc_q <= pcPlus4;
            end
          end
        end
        RUN: begin
          // A misaligned redirect target is never taken; the old pc is kept for debug.
          if (bus.halt_req) begin
            state_q <= HALT;
          end else if (bus.redirect) begin
            if (bus.redirect_pc[1:0] != 2'b00) begin
              state_q    <= HALT;
              misalign_q <= 1'b1;
            end else begin
              pc_q <= bus.redirect_pc;
            end
          end else if (!bus.stall) begin
            pc_q <= pcPlus4;
          end
        end
      endcase
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [XLEN-1:0] runCycles_q, runCycles_d;
  logic [XLEN-1:0] fetchCount_q, fetchCount_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    runCycles_d  = runCycles_q;
    fetchCount_d = fetchCount_q;
    if (startAccept) begin
      runCycles_d  = '0;
      fetchCount_d = '0;
    end else begin
      if ((state_q == RUN) && !(&runCycles_q)) begin
        runCycles_d = runCycles_q + XLEN'(1);
      end
      if (bus.fetch_valid && !(&fetchCount_q)) begin
        fetchCount_d = fetchCount_q + XLEN'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      runCycles_q  <= '0;
      fetchCount_q <= '0;
    end else begin
      runCycles_q  <= runCycles_d;
      fetchCount_q <= fetchCount_d;
    end
  end

  assign bus.run_cycles  = runCycles_q;
  assign bus.fetch_count = fetchCount_q;
`else
  assign bus.run_cycles  = '0;
  assign bus.fetch_count = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: directed scenarios plus random traffic against a
// behavioural model; memory writes and fetches are checked by a separate negedge monitor.
module tb_fetch_ctrl;
  localparam int          XLEN     = 32;
  localparam int          ILEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam longint      PC_MOD   = 64'h1_0000_0000;
  localparam longint      CNT_MAX  = (64'd1 << XLEN) - 1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  fetch_ctrl_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

  fetch_ctrl #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RESET_PC)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    bit          isWrite;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t   expQ[$];
  exp_t   mon;
  int     total = 0;
  int     bad = 0;
  int     curCycle = 0;

  // Behavioural model: mode 0 idle, 1 loading, 2 running, 3 halted.
  int     mMode = 0;
  longint mPc = RESET_PC;
  bit     mMis = 1'b0;
  longint mRun = 0;
  longint mFetch = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, curCycle, actual, expected);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_state"}, 64'(bus.state), 64'(mMode));
    checkOutput({tag, "_pc"}, 64'(bus.pc), 64'(mPc));
    checkOutput({tag, "_misalign"}, 64'(bus.misalign_err), 64'(mMis));
`ifdef FETCH_CTRL_PERF_EN
    checkOutput({tag, "_run_cycles"}, 64'(bus.run_cycles), 64'(mRun));
    checkOutput({tag, "_fetch_count"}, 64'(bus.fetch_count), 64'(mFetch));
`else
    checkOutput({tag, "_run_cycles"}, 64'(bus.run_cycles), 64'd0);
    checkOutput({tag, "_fetch_count"}, 64'(bus.fetch_count), 64'd0);
`endif
  endtask

  function automatic longint satInc(input longint v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // One clock cycle: drive inputs, predict this cycle's outputs and the next state.
  task automatic applyStimulus(input bit st, input bit sl, input bit hr, input bit lv,
                               input logic [31:0] ld, input bit last, input bit stl,
                               input bit rd, input logic [31:0] rpc);
    exp_t e;
    bus.start       = st;
    bus.start_load  = sl;
    bus.halt_req    = hr;
    bus.load_valid  = lv;
    bus.load_data   = ld;
    bus.load_last   = last;
    bus.stall       = stl;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    curCycle++;
    case (mMode)
      0, 3: begin
        if (st) begin
          mRun   = 0;
          mFetch = 0;
        end
        if (sl) begin
          mMode = 1; mPc = RESET_PC; mMis = 1'b0;
        end else if (st) begin
          mMode = 2; mPc = RESET_PC; mMis = 1'b0;
        end
      end
      1: begin
        if (lv) begin
          e.isWrite = 1'b1; e.addr = 32'(mPc); e.data = ld; e.cyc = curCycle;
          expQ.push_back(e);
          if (last) begin
            mMode = 0; mPc = RESET_PC;
          end else begin
            mPc = (mPc + 4) % PC_MOD;
          end
        end
      end
      default: begin
        mRun = satInc(mRun);
        if (!stl) begin
          e.isWrite = 1'b0; e.addr = 32'(mPc); e.data = 32'h0; e.cyc = curCycle;
          expQ.push_back(e);
          mFetch = satInc(mFetch);
        end
        if (hr) begin
          mMode = 3;
        end else if (rd) begin
          if ((longint'(rpc) % 4) != 0) begin
            mMode = 3; mMis = 1'b1;
          end else begin
            mPc = longint'(rpc);
          end
        end else if (!stl) begin
          mPc = (mPc + 4) % PC_MOD;
        end
      end
    endcase
    @(posedge clock);
    #1;
    checkState("cyc");
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  // Reset lands between clock edges and must take effect without waiting for one.
  task automatic doReset();
    bus.start = 0; bus.start_load = 0; bus.halt_req = 0; bus.load_valid = 0;
    bus.load_data = '0; bus.load_last = 0; bus.stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
    reset_n = 1'b0;
    #1;
    mMode = 0; mPc = RESET_PC; mMis = 1'b0; mRun = 0; mFetch = 0;
    checkState("reset");
    checkOutput("reset_fetch_valid", 64'(bus.fetch_valid), 64'd0);
    checkOutput("reset_load_ready", 64'(bus.load_ready), 64'd0);
    checkOutput("reset_write_en", 64'(bus.write_en), 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      while (expQ.size() > 0 && expQ[0].cyc < curCycle) begin
        mon = expQ.pop_front();
        total++;
        bad++;
        $display("[TB] FAIL missing_event cycle %0d: got none expected %s at %0h",
                 mon.cyc, mon.isWrite ? "write" : "fetch", mon.addr);
      end
      if (bus.write_en === 1'b1 || bus.fetch_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_event cycle %0d: got we=%0b fv=%0b pc=%0h expected none",
                   curCycle, bus.write_en, bus.fetch_valid, bus.pc);
        end else begin
          mon = expQ.pop_front();
          checkOutput("evt_cycle", 64'(curCycle), 64'(mon.cyc));
          checkOutput("evt_kind", 64'({bus.write_en, bus.fetch_valid}), mon.isWrite ? 64'd2 : 64'd1);
          checkOutput("evt_addr", 64'(bus.pc), 64'(mon.addr));
          if (mon.isWrite) checkOutput("evt_wdata", 64'(bus.wdata), 64'(mon.data));
        end
      end else begin
        checkOutput("wdata_quiet", 64'(bus.wdata), 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rp;
    doReset();
    checkState("post_reset");

    // Three-word program load.
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h11, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h22, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h33, 1, 0, 0, 32'h0);
    idleCycle();

    // Load with a two-cycle gap in load_valid; start is ignored while loading.
    applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'hA1, 0, 0, 0, 32'h0);
    applyStimulus(1, 0, 1, 0, 32'hDEAD, 0, 1, 1, 32'h40);
    applyStimulus(0, 0, 0, 0, 32'hBEEF, 1, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'hA2, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'hA3, 1, 0, 0, 32'h0);

    // Run: four free, two stalled, two free.
    applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    repeat (4) idleCycle();
    repeat (2) applyStimulus(0, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0);
    repeat (2) idleCycle();

    // Priority: redirect beats stall, halt beats redirect.
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 1, 1, 32'h100);
    idleCycle();
    applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 1, 32'h200);
    applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 1, 32'h300);

    // Misaligned redirect halts with a sticky error; start clears it.
    applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    idleCycle();
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h102);
    idleCycle();
    applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    idleCycle();

    // Reset in the middle of a run at pc 0x40.
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'h3C);
    idleCycle();
    doReset();
    idleCycle();

    // Address wrap at the top of the space.
    applyStimulus(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 1, 32'hFFFF_FFF8);
    repeat (3) idleCycle();
    applyStimulus(0, 0, 1, 0, 32'h0, 0, 0, 0, 32'h0);

    // Random traffic, including inputs that must be ignored in the current mode.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) doReset();
      rp = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0, $urandom,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) == 0, rp);
    end

    doReset();
    repeat (2) idleCycle();
    checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
